psc_trigger_frame_scheduler: RTL and testbench
==============================================

PSC_TRIGGER_FRAME_SCHEDULER -- requirements
Module: psc_trigger_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 10: bytes per frame, range 2..16.
REQ-002 SHALL have parameter IDLE_PERIOD, default 100: idle byte slots before a keepalive frame, range 2..1023.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port byte_strobe, input, 1: one-cycle pulse marking each byte-slot boundary.
REQ-006 SHALL have port trigger_req, input, 1: one-cycle trigger request pulse.
REQ-007 SHALL have port status_req, input, 1: one-cycle status-frame request pulse.
REQ-008 SHALL have port tx_counter, output, 4: ROM byte address within the current frame.
REQ-009 SHALL have port frame_type, output, 2: 00 none, 01 trigger, 10 status, 11 keepalive.
REQ-010 SHALL have port is_trigger, output, 1: high when frame_type is 01.
REQ-011 SHALL have port frame_active, output, 1: high while a frame occupies byte slots.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse at frame completion.
REQ-013 SHALL have port trigger_drop_count, output, 8: count of dropped trigger requests, saturating.

Function
REQ-014 SHALL implement states IDLE, TRIG, STAT and KEEP; all outputs registered.
REQ-015 SHALL latch trigger_req and status_req into independent pending flags on the cycle they are asserted.
REQ-016 SHALL, in IDLE on byte_strobe, start the highest-priority pending frame: trigger > status > keepalive.
REQ-017 SHALL, on frame start, clear that frame's pending flag, set tx_counter=0, set frame_active=1 and set frame_type, all visible the cycle after the strobe.
REQ-018 SHALL re-latch a request of the same type that arrives in the frame-start cycle, leaving its pending flag set.
REQ-019 SHALL increment tx_counter on each byte_strobe while in a frame.
REQ-020 SHALL, on the byte_strobe with tx_counter=FRAME_LEN-1, pulse frame_done for 1 cycle, return to IDLE, and set tx_counter=0, frame_type=00 and frame_active=0.
REQ-021 SHALL return to IDLE after each frame; back-to-back frames are separated by exactly one idle byte slot.
REQ-022 SHALL, when trigger_req arrives with the trigger pending flag already set, drop the request and increment trigger_drop_count, saturating at 255.
REQ-023 SHALL latch trigger_req and status_req independently when they arrive in the same cycle, with no drop.
REQ-024 SHALL ignore byte_strobe and requests in no other way: requests arriving mid-frame stay pending until IDLE.

Reset
REQ-025 SHALL, on reset assertion, immediately force state IDLE, clear pending flags, clear the idle counter, and drive tx_counter=0, frame_type=00, is_trigger=0, frame_active=0, frame_done=0 and trigger_drop_count=0.
REQ-026 SHALL abort an in-progress frame on reset without pulsing frame_done.

Configuration
REQ-027 SHALL, with macro PSC_TRIGGER_KEEPALIVE_EN defined, count byte_strobes in IDLE with no pending flag and set keepalive pending when the count reaches IDLE_PERIOD; the counter clears on any frame start.
REQ-028 SHALL, without PSC_TRIGGER_KEEPALIVE_EN, omit the idle counter and KEEP state; frame_type never equals 11.

Verification
REQ-029 SHALL cover: reset, then trigger_req with strobes every 5 cycles -> frame_type=01, tx_counter 0..9, frame_done after 10th strobe.
REQ-030 SHALL cover: trigger_req and status_req in the same cycle -> trigger frame, one idle slot, then status frame; drop count 0.
REQ-031 SHALL cover: 3 trigger_req during an active trigger frame -> one pending, trigger_drop_count=2.
REQ-032 SHALL cover: 300 drops -> trigger_drop_count holds at 255.
REQ-033 SHALL cover: with KEEPALIVE_EN and no requests -> keepalive frame starts on the 101st idle strobe; without the macro -> no frame after 1000 strobes.
REQ-034 SHALL cover: reset asserted at tx_counter=4 -> all outputs 0 within the same cycle, no frame_done.

Source files
------------

// File: rtl/psc_trigger_frame_scheduler_if.sv
// Byte-slot scheduler bus: strobe/request inputs and frame status outputs.
// The testbench or upstream logic takes master; the scheduler takes slave.
interface psc_trigger_frame_scheduler_if;
  logic       byte_strobe;
  logic       trigger_req;
  logic       status_req;
  logic [3:0] tx_counter;
  logic [1:0] frame_type;
  logic       is_trigger;
  logic       frame_active;
  logic       frame_done;
  logic [7:0] trigger_drop_count;

  modport master (
    output byte_strobe, trigger_req, status_req,
    input  tx_counter, frame_type, is_trigger, frame_active, frame_done, trigger_drop_count
  );

  modport slave (
    input  byte_strobe, trigger_req, status_req,
    output tx_counter, frame_type, is_trigger, frame_active, frame_done, trigger_drop_count
  );
endinterface

// File: rtl/psc_trigger_frame_scheduler.sv
// Arbitrates trigger, status and keepalive frames onto byte slots; all outputs registered.
// Keepalive generation is built only when PSC_TRIGGER_KEEPALIVE_EN is defined.
module psc_trigger_frame_scheduler #(
  parameter int FRAME_LEN   = 10,
  parameter int IDLE_PERIOD = 100
) (
  input logic                          clk,
  input logic                          reset,
  psc_trigger_frame_scheduler_if.slave bus
);
  // state | meaning
  // IDLE  | no frame; next byte_strobe starts the highest-priority pending frame
  // TRIG  | trigger frame occupying byte slots
  // STAT  | status frame occupying byte slots
  // KEEP  | keepalive frame (keepalive build only)
`ifdef PSC_TRIGGER_KEEPALIVE_EN
  typedef enum logic [1:0] {IDLE = 2'b00, TRIG = 2'b01, STAT = 2'b10, KEEP = 2'b11} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'b00, TRIG = 2'b01, STAT = 2'b10} state_t;
`endif

  localparam logic [3:0] LAST_SLOT = 4'(FRAME_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] type_q;
  logic       is_trig_q, active_q, done_q, done_d;
  logic [7:0] drop_q;
  logic       trig_pend_q, stat_pend_q;
  logic       start_trig, start_stat;
  logic       drop_inc;

`ifdef PSC_TRIGGER_KEEPALIVE_EN
  localparam int IDLE_W = $clog2(IDLE_PERIOD + 1);
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              keep_pend_q, start_keep, idle_tick, frame_start;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    start_trig = 1'b0;
    start_stat = 1'b0;
`ifdef PSC_TRIGGER_KEEPALIVE_EN
    start_keep = 1'b0;
`endif
    if (bus.byte_strobe) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (trig_pend_q) begin
            state_d    = TRIG;
            start_trig = 1'b1;
          end else if (stat_pend_q) begin
            state_d    = STAT;
            start_stat = 1'b1;
          end
`ifdef PSC_TRIGGER_KEEPALIVE_EN
          else if (keep_pend_q) begin
            state_d    = KEEP;
            start_keep = 1'b1;
          end
`endif
        end
        default: begin
          if (cnt_q == LAST_SLOT) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  // A trigger arriving while its own frame starts re-arms the flag instead of dropping
  assign drop_inc = bus.trigger_req & trig_pend_q & ~start_trig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= 2'b00;
      is_trig_q   <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= '0;
      trig_pend_q <= 1'b0;
      stat_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      type_q      <= state_d;
      is_trig_q   <= (state_d == TRIG);
      active_q    <= (state_d != IDLE);
      done_q      <= done_d;
      trig_pend_q <= start_trig ? bus.trigger_req : (trig_pend_q | bus.trigger_req);
      stat_pend_q <= start_stat ? bus.status_req  : (stat_pend_q | bus.status_req);
      if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

`ifdef PSC_TRIGGER_KEEPALIVE_EN
  assign frame_start = start_trig | start_stat | start_keep;
  assign idle_tick   = (state_q == IDLE) && bus.byte_strobe &&
                       !trig_pend_q && !stat_pend_q && !keep_pend_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q  <= '0;
      keep_pend_q <= 1'b0;
    end else begin
      if (frame_start)    idle_cnt_q <= '0;
      else if (idle_tick) idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      if (start_keep) keep_pend_q <= 1'b0;
      else if (idle_tick && (idle_cnt_q + IDLE_W'(1)) == IDLE_W'(IDLE_PERIOD)) keep_pend_q <= 1'b1;
    end
  end
`endif

  assign bus.tx_counter         = cnt_q;
  assign bus.frame_type         = type_q;
  assign bus.is_trigger         = is_trig_q;
  assign bus.frame_active       = active_q;
  assign bus.frame_done         = done_q;
  assign bus.trigger_drop_count = drop_q;
endmodule

// File: tb/tb_psc_trigger_frame_scheduler.sv
// Bench for psc_trigger_frame_scheduler: directed scenarios plus random traffic against a slot-level model.
// Honours PSC_TRIGGER_KEEPALIVE_EN the same way the design does.
module tb_psc_trigger_frame_scheduler;
  localparam int FL = 10;
  localparam int IP = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psc_trigger_frame_scheduler_if bus();

  psc_trigger_frame_scheduler #(.FRAME_LEN(FL), .IDLE_PERIOD(IP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: current frame kind (0 none,1 trig,2 stat,3 keep), slot within it, pending requests
  int m_type, m_slot, m_drop;
  bit m_pt, m_ps, m_done;
`ifdef PSC_TRIGGER_KEEPALIVE_EN
  bit m_pk;
  int m_idle;
`endif

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_type = 0; m_slot = 0; m_drop = 0; m_pt = 0; m_ps = 0; m_done = 0;
`ifdef PSC_TRIGGER_KEEPALIVE_EN
    m_pk = 0; m_idle = 0;
`endif
  endtask

  task automatic model_step(bit s, bit t, bit q);
    int  started = 0;
    bit  idle    = (m_type == 0);
    m_done = 0;
    if (idle && s) begin
      if (m_pt)      started = 1;
      else if (m_ps) started = 2;
`ifdef PSC_TRIGGER_KEEPALIVE_EN
      else if (m_pk) started = 3;
      else begin
        m_idle++;
        if (m_idle == IP) m_pk = 1;
      end
`endif
    end
    if (!idle && s) begin
      if (m_slot == FL - 1) begin
        m_type = 0; m_slot = 0; m_done = 1;
      end else m_slot++;
    end
    if (started != 0) begin
      m_type = started; m_slot = 0;
      if (started == 1) m_pt = 0;
      if (started == 2) m_ps = 0;
`ifdef PSC_TRIGGER_KEEPALIVE_EN
      if (started == 3) m_pk = 0;
      m_idle = 0;
`endif
    end
    if (t) begin
      if (m_pt) begin
        if (m_drop < 255) m_drop++;
      end else m_pt = 1;
    end
    if (q) m_ps = 1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx_counter",   int'(bus.tx_counter),         m_slot);
      check("frame_type",   int'(bus.frame_type),         m_type);
      check("is_trigger",   int'(bus.is_trigger),         int'(m_type == 1));
      check("frame_active", int'(bus.frame_active),       int'(m_type != 0));
      check("frame_done",   int'(bus.frame_done),         int'(m_done));
      check("drop_count",   int'(bus.trigger_drop_count), m_drop);
    end
  end

  task automatic tick(bit s, bit t, bit q);
    bus.byte_strobe = s; bus.trigger_req = t; bus.status_req = q;
    @(posedge clk);
    model_step(s, t, q);
    @(negedge clk);
    bus.byte_strobe = 1'b0; bus.trigger_req = 1'b0; bus.status_req = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_tx"},     int'(bus.tx_counter),         0);
    check({tag, "_type"},   int'(bus.frame_type),         0);
    check({tag, "_istrig"}, int'(bus.is_trigger),         0);
    check({tag, "_active"}, int'(bus.frame_active),       0);
    check({tag, "_done"},   int'(bus.frame_done),         0);
    check({tag, "_drop"},   int'(bus.trigger_drop_count), 0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    reset  = 1'b1;
    bus.byte_strobe = 1'b0; bus.trigger_req = 1'b0; bus.status_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    @(negedge clk);

    // Trigger frame, strobes every 5 cycles
    do_reset();
    tick(0, 1, 0);
    tick(0, 0, 0);
    for (int i = 0; i <= FL; i++) begin
      tick(1, 0, 0);
      if (i == 0) begin
        check("a_type",   int'(bus.frame_type), 1);
        check("a_istrig", int'(bus.is_trigger), 1);
      end
      if (i < FL) check("a_tx", int'(bus.tx_counter), i);
      else begin
        check("a_done",   int'(bus.frame_done),   1);
        check("a_active", int'(bus.frame_active), 0);
      end
      repeat (4) tick(0, 0, 0);
    end

    // Simultaneous trigger and status: trigger, one idle slot, status
    do_reset();
    tick(0, 1, 1);
    for (int i = 0; i <= 2 * FL + 1; i++) begin
      tick(1, 0, 0);
      if (i == FL)     check("b_gap",  int'(bus.frame_active), 0);
      if (i == FL + 1) check("b_stat", int'(bus.frame_type),   2);
      tick(0, 0, 0);
    end
    check("b_drop", int'(bus.trigger_drop_count), 0);

    // Three triggers during an active trigger frame
    do_reset();
    tick(0, 1, 0);
    tick(1, 0, 0);
    repeat (3) begin tick(0, 1, 0); tick(0, 0, 0); end
    check("c_drop", int'(bus.trigger_drop_count), 2);
    for (int i = 1; i <= FL + 1; i++) tick(1, 0, 0);
    check("c_retrig", int'(bus.frame_type), 1);
    check("c_drop2",  int'(bus.trigger_drop_count), 2);

    // Drop counter saturation
    do_reset();
    tick(0, 1, 0);
    repeat (10) tick(0, 1, 0);
    check("d_drop10", int'(bus.trigger_drop_count), 10);
    repeat (290) tick(0, 1, 0);
    check("d_sat", int'(bus.trigger_drop_count), 255);

    // Idle behaviour with no requests
    do_reset();
`ifdef PSC_TRIGGER_KEEPALIVE_EN
    for (int i = 1; i <= IP; i++) begin tick(1, 0, 0); tick(0, 0, 0); end
    check("e_pre_keep", int'(bus.frame_active), 0);
    tick(1, 0, 0);
    check("e_keep", int'(bus.frame_type), 3);
`else
    seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick(1, 0, 0);
      seen += int'(bus.frame_active);
      tick(0, 0, 0);
    end
    check("e_no_frame", seen, 0);
`endif

    // Reset in the middle of a frame
    do_reset();
    tick(0, 1, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    repeat (4) tick(1, 0, 0);
    check("f_tx4", int'(bus.tx_counter), 4);
    chk_en = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("f_async");
    model_reset();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(bus.frame_done);
    end
    check("f_no_done", seen, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 24) == 0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
